// File: rtl/code_lock_ctrl.sv
// rtl/code_lock_ctrl.sv - multi-digit combination lock with failure lockout, code change and idle relock
module code_lock_ctrl #(
  parameter int                          DIGIT_W      = 4,
  parameter int                          CODE_LEN     = 4,
  parameter int                          MAX_FAIL     = 3,
  parameter int                          LOCKOUT_CYC  = 50000000,
  parameter int                          TIMEOUT_CYC  = 500000000,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1A2B
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIGIT_W-1:0]              digit_in,
  input  logic                            digit_stb,
  input  logic                            enter_stb,
  input  logic                            change_stb,
  input  logic                            clear_stb,
  output logic                            open,
  output logic                            alarm,
  output logic                            change_mode,
  output logic                            fail_pulse,
  output logic [$clog2(CODE_LEN+1)-1:0]   entry_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int CW = DIGIT_W * CODE_LEN;
  localparam int EW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_CHG,
    S_LOCKOUT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] code, code_nxt;
  logic [CW-1:0] buffer, buf_nxt;
  logic [EW-1:0] ecnt_nxt;
  logic [FW-1:0] fcnt_nxt;
  logic [TW-1:0] idle_tmr, idle_nxt;
  logic [LW-1:0] lock_tmr, lock_nxt;
  logic          fpulse_nxt;
  logic          any_stb;
  logic          entry_full;
  logic          fail_last;

  assign any_stb    = digit_stb | enter_stb | change_stb | clear_stb;
  assign entry_full = (entry_cnt == EW'(CODE_LEN));
  assign fail_last  = (fail_cnt == FW'(MAX_FAIL - 1));

  always_comb begin
    state_nxt  = state;
    code_nxt   = code;
    buf_nxt    = buffer;
    ecnt_nxt   = entry_cnt;
    fcnt_nxt   = fail_cnt;
    idle_nxt   = '0;
    lock_nxt   = '0;
    fpulse_nxt = 1'b0;

    unique case (state)
      S_IDLE, S_ENTRY: begin
        if (clear_stb) begin
          state_nxt = S_IDLE;
          buf_nxt   = '0;
          ecnt_nxt  = '0;
        end else if (enter_stb) begin
          buf_nxt  = '0;
          ecnt_nxt = '0;
          if (entry_full && (buffer == code)) begin
            state_nxt = S_OPEN;
            fcnt_nxt  = '0;
          end else begin
            fpulse_nxt = 1'b1;
            fcnt_nxt   = fail_cnt + 1'b1;
            state_nxt  = fail_last ? S_LOCKOUT : S_IDLE;
          end
        end else if (change_stb) begin
          state_nxt = state;
        end else if (digit_stb) begin
          state_nxt = S_ENTRY;
          if (!entry_full) begin
            buf_nxt  = (buffer << DIGIT_W) | CW'(digit_in);
            ecnt_nxt = entry_cnt + 1'b1;
          end
        end
      end

      S_OPEN: begin
        if (clear_stb || enter_stb) begin
          state_nxt = S_IDLE;
        end else if (change_stb) begin
          state_nxt = S_CHG;
          buf_nxt   = '0;
          ecnt_nxt  = '0;
        end
      end

      S_CHG: begin
        if (clear_stb || enter_stb) begin
          // A short entry on commit leaves the stored code alone
          if (!clear_stb && entry_full) code_nxt = buffer;
          state_nxt = S_OPEN;
          buf_nxt   = '0;
          ecnt_nxt  = '0;
        end else if (!change_stb && digit_stb && !entry_full) begin
          buf_nxt  = (buffer << DIGIT_W) | CW'(digit_in);
          ecnt_nxt = entry_cnt + 1'b1;
        end
      end

      S_LOCKOUT: begin
        if (lock_tmr == LW'(LOCKOUT_CYC - 1)) begin
          state_nxt = S_IDLE;
          fcnt_nxt  = '0;
        end else begin
          lock_nxt = lock_tmr + 1'b1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    // Inactivity timer overrides the case above only on strobe-free cycles
    if ((state == S_ENTRY || state == S_OPEN || state == S_CHG) && !any_stb) begin
      if (idle_tmr == TW'(TIMEOUT_CYC - 1)) begin
        state_nxt = S_IDLE;
        buf_nxt   = '0;
        ecnt_nxt  = '0;
      end else begin
        idle_nxt = idle_tmr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      code        <= DEFAULT_CODE;
      buffer      <= '0;
      entry_cnt   <= '0;
      fail_cnt    <= '0;
      idle_tmr    <= '0;
      lock_tmr    <= '0;
      open        <= 1'b0;
      alarm       <= 1'b0;
      change_mode <= 1'b0;
      fail_pulse  <= 1'b0;
    end else begin
      state       <= state_nxt;
      code        <= code_nxt;
      buffer      <= buf_nxt;
      entry_cnt   <= ecnt_nxt;
      fail_cnt    <= fcnt_nxt;
      idle_tmr    <= idle_nxt;
      lock_tmr    <= lock_nxt;
      open        <= (state_nxt == S_OPEN) || (state_nxt == S_CHG);
      alarm       <= (state_nxt == S_LOCKOUT);
      change_mode <= (state_nxt == S_CHG);
      fail_pulse  <= fpulse_nxt;
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb/tb_code_lock_ctrl.sv - directed table-driven bench for code_lock_ctrl
module tb_code_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_in;
  logic       digit_stb, enter_stb, change_stb, clear_stb;
  logic       open, alarm, change_mode, fail_pulse;
  logic [2:0] entry_cnt;
  logic [1:0] fail_cnt;

  int errors = 0;
  int checks = 0;

  code_lock_ctrl #(
    .DIGIT_W(4), .CODE_LEN(4), .MAX_FAIL(3),
    .LOCKOUT_CYC(20), .TIMEOUT_CYC(50), .DEFAULT_CODE(16'h1A2B)
  ) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_stb(digit_stb),
    .enter_stb(enter_stb), .change_stb(change_stb), .clear_stb(clear_stb),
    .open(open), .alarm(alarm), .change_mode(change_mode), .fail_pulse(fail_pulse),
    .entry_cnt(entry_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       ds, es, cs, cl;
    logic       o, a, c, fp;
    int         ec, fc;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic o, a, c, fp, input int ec, fc);
    chk({tag, " open"}, int'(open), int'(o));
    chk({tag, " alarm"}, int'(alarm), int'(a));
    chk({tag, " change_mode"}, int'(change_mode), int'(c));
    chk({tag, " fail_pulse"}, int'(fail_pulse), int'(fp));
    chk({tag, " entry_cnt"}, int'(entry_cnt), ec);
    chk({tag, " fail_cnt"}, int'(fail_cnt), fc);
  endtask

  task automatic step(input logic [3:0] d, input logic ds, es, cs, cl);
    digit_in   = d;
    digit_stb  = ds;
    enter_stb  = es;
    change_stb = cs;
    clear_stb  = cl;
    @(posedge clk);
    #1;
    digit_stb  = 1'b0;
    enter_stb  = 1'b0;
    change_stb = 1'b0;
    clear_stb  = 1'b0;
  endtask

  function automatic void add(input logic [3:0] d, input logic ds, es, cs, cl,
                              input logic o, a, c, fp, input int ec, fc, input string name);
    vec_t v;
    v.d = d; v.ds = ds; v.es = es; v.cs = cs; v.cl = cl;
    v.o = o; v.a = a; v.c = c; v.fp = fp; v.ec = ec; v.fc = fc; v.name = name;
    tbl.push_back(v);
  endfunction

  function automatic void add_code(input logic [15:0] code, input logic o, c, input int fc,
                                   input string name);
    logic [15:0] cv;
    cv = code;
    for (int k = 0; k < 4; k++)
      add(cv[15-4*k -: 4], 1, 0, 0, 0, o, 0, c, 0, k + 1, fc, name);
  endfunction

  task automatic run_table();
    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].ds, tbl[i].es, tbl[i].cs, tbl[i].cl);
      check_out(tbl[i].name, tbl[i].o, tbl[i].a, tbl[i].c, tbl[i].fp, tbl[i].ec, tbl[i].fc);
    end
    tbl.delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'h0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    digit_in = '0; digit_stb = 0; enter_stb = 0; change_stb = 0; clear_stb = 0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // correct default code, relock, then three wrong entries into lockout
    add_code(16'h1A2B, 0, 0, 0, "open_dig");
    add(4'h0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "open_enter");
    add(4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "relock");
    for (int r = 1; r <= 3; r++) begin
      add_code(16'h1A2C, 0, 0, r - 1, "wrong_dig");
      add(4'h0, 0, 1, 0, 0, 0, (r == 3), 0, 1, 0, r, "wrong_enter");
    end
    run_table();

    for (int i = 1; i <= 19; i++) begin
      step(4'h1, (i % 2 == 1), (i % 3 == 0), (i % 5 == 0), (i == 7));
      check_out("lockout", 0, 1, 0, 0, 0, 3);
    end
    step(4'h0, 0, 0, 0, 0);
    check_out("lockout_end", 0, 0, 0, 0, 0, 0);

    // open, change code to 5567, relock, old code fails, new opens
    add_code(16'h1A2B, 0, 0, 0, "post_lock_dig");
    add(4'h0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "post_lock_open");
    add(4'h0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, "change");
    add_code(16'h5567, 1, 1, 0, "chg_dig");
    add(4'h0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "chg_commit");
    add(4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "chg_relock");
    add_code(16'h1A2B, 0, 0, 0, "old_dig");
    add(4'h0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, "old_fails");
    add_code(16'h5567, 0, 0, 1, "new_dig");
    add(4'h0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "new_opens");
    add(4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "new_relock");
    run_table();

    // partial entry timeout keeps fail_cnt
    step(4'h0, 0, 1, 0, 0);
    check_out("empty_submit", 0, 0, 0, 1, 0, 1);
    step(4'h1, 1, 0, 0, 0);
    step(4'hA, 1, 0, 0, 0);
    idle(49);
    check_out("entry_49_idle", 0, 0, 0, 0, 2, 1);
    idle(1);
    check_out("entry_timeout", 0, 0, 0, 0, 0, 1);

    // open lock relocks after 50 idle cycles
    add_code(16'h5567, 0, 0, 1, "to_dig");
    add(4'h0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "to_open");
    run_table();
    idle(49);
    check_out("open_49_idle", 1, 0, 0, 0, 0, 0);
    idle(1);
    check_out("open_timeout", 0, 0, 0, 0, 0, 0);

    // reset during CHG_ENTRY restores default code
    add_code(16'h5567, 0, 0, 0, "rst_dig");
    add(4'h0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "rst_open");
    add(4'h0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, "rst_change");
    add(4'h3, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, "rst_chg_dig");
    run_table();
    #3 rst = 1'b0;
    #1;
    check_out("async_reset", 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    add_code(16'h1A2B, 0, 0, 0, "def_dig");
    add(4'h0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "default_restored");
    add(4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "def_relock");

    // saturation and clear-over-enter priority
    add_code(16'h1A2B, 0, 0, 0, "sat_dig");
    add(4'h9, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0, "sat_extra");
    add(4'h0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "sat_open");
    add(4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "sat_relock");
    add_code(16'h1A2B, 0, 0, 0, "prio_dig");
    add(4'h0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, "clear_enter");
    add(4'h7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "after_clear");
    add(4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "clear");
    run_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
